stump_control: RTL and testbench

//  Sequencer for the Stump 16-bit CPU: owns state register FETCH/EXECUTE/MEMORY and instruction register (IR).

---
 rtl/stump_control.sv | 164 ++++++++++++++++
 tb/tb_stump_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stump_control.sv
// Stump 16-bit CPU control: FETCH/EXECUTE/MEMORY sequencer, instruction register,
// ISA decode and branch-condition evaluation, with a mem_ready stall handshake.
module stump_control #(
  parameter logic [2:0] PC_REG  = 3'd7,
  parameter bit         WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        mem_ready,
  input  logic [3:0]  cc,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic [15:0] ir,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic        imm_sel,
  output logic        imm8_sel,
  output logic [1:0]  shift_op,
  output logic [2:0]  alu_func,
  output logic        cc_en,
  output logic        addr_sel,
  output logic        mem_ren,
  output logic        mem_wen
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_MEMORY  = 2'b10
  } state_t;

  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;
  localparam logic [2:0] ALU_ADD = 3'b000;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        run_q;

  logic       rdy;
  logic [2:0] op;
  logic       flag_n, flag_z, flag_v, flag_c;
  logic       cond_base, taken;
  logic       wr_c, ren_c, imm_sel_c;

  assign rdy = WAIT_EN ? mem_ready : 1'b1;
  assign op  = ir_q[15:13];
  assign {flag_n, flag_z, flag_v, flag_c} = cc;

  // Odd condition codes are the complement of the even code below them.
  always_comb begin
    cond_base = 1'b1;
    case (ir_q[11:9])
      3'd0: cond_base = 1'b1;
      3'd1: cond_base = ~flag_c & ~flag_z;
      3'd2: cond_base = ~flag_c;
      3'd3: cond_base = ~flag_z;
      3'd4: cond_base = ~flag_v;
      3'd5: cond_base = ~flag_n;
      3'd6: cond_base = (flag_n == flag_v);
      3'd7: cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
  end
  assign taken = cond_base ^ ir_q[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    ir_d      = ir_q;
    fetch     = 1'b0;
    execute   = 1'b0;
    memory    = 1'b0;
    wr_c      = 1'b0;
    ren_c     = 1'b0;
    mem_wen   = 1'b0;
    dest      = ir_q[10:8];
    srcA      = ir_q[7:5];
    srcB      = ir_q[4:2];
    imm_sel_c = 1'b0;
    imm8_sel  = 1'b0;
    alu_func  = op;
    cc_en     = 1'b0;
    addr_sel  = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch = 1'b1;
        ren_c = 1'b1;
        srcA  = PC_REG;
        dest  = PC_REG;
        wr_c  = rdy;
        // No instruction is taken until the first post-reset edge has set run.
        if (run_q && rdy) begin
          ir_d    = data_in;
          state_d = S_EXECUTE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        execute = 1'b1;
        state_d = S_FETCH;
        case (op)
          OP_LDST: begin
            alu_func  = ALU_ADD;
            imm_sel_c = 1'b1;
            state_d   = S_MEMORY;
          end
          OP_BCC: begin
            if (taken) begin
              srcA      = PC_REG;
              dest      = PC_REG;
              imm_sel_c = 1'b1;
              imm8_sel  = 1'b1;
              alu_func  = ALU_ADD;
              wr_c      = 1'b1;
            end
          end
          default: begin
            wr_c      = 1'b1;
            imm_sel_c = ir_q[12];
            cc_en     = ir_q[11];
          end
        endcase
      end
      S_MEMORY: begin
        memory   = 1'b1;
        addr_sel = 1'b1;
        alu_func = ALU_ADD;
        if (ir_q[11]) begin
          mem_wen = 1'b1;
          srcA    = ir_q[10:8];
        end else begin
          ren_c = 1'b1;
          wr_c  = rdy;
        end
        state_d = rdy ? S_FETCH : S_MEMORY;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ir        = ir_q;
  assign imm_sel   = imm_sel_c;
  assign shift_op  = imm_sel_c ? 2'b00 : ir_q[1:0];
  assign mem_ren   = ren_c & run_q;
  assign reg_write = wr_c & run_q;

endmodule

// File: tb/tb_stump_control.sv
// Directed bench for stump_control: reset, ALU/LD/ST/branch sequences, wait states,
// full branch-condition sweep and reset during a store.
module tb_stump_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        mem_ready = 1'b1;
  logic [3:0]  cc = 4'h0;
  logic        fetch, execute, memory, reg_write, imm_sel, imm8_sel, cc_en, addr_sel, mem_ren, mem_wen;
  logic [15:0] ir;
  logic [2:0]  dest, srcA, srcB, alu_func;
  logic [1:0]  shift_op;

  int n_cmp = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  stump_control dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mem_ready(mem_ready), .cc(cc),
    .fetch(fetch), .execute(execute), .memory(memory), .ir(ir), .reg_write(reg_write),
    .dest(dest), .srcA(srcA), .srcB(srcB), .imm_sel(imm_sel), .imm8_sel(imm8_sel),
    .shift_op(shift_op), .alu_func(alu_func), .cc_en(cc_en), .addr_sel(addr_sel),
    .mem_ren(mem_ren), .mem_wen(mem_wen)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bcc_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return !cy && !z;
      4'h3: return cy || z;
      4'h4: return !cy;
      4'h5: return cy;
      4'h6: return !z;
      4'h7: return z;
      4'h8: return !v;
      4'h9: return v;
      4'hA: return !n;
      4'hB: return n;
      4'hC: return n == v;
      4'hD: return n != v;
      4'hE: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  // Called during the low phase of a FETCH cycle; returns 1ns into the EXECUTE cycle.
  task automatic do_fetch(input logic [15:0] instr);
    data_in   = instr;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", 16'(fetch), 16'd1);
    chk("fetch_ren", 16'(mem_ren), 16'd1);
    chk("fetch_wr", 16'(reg_write), 16'd1);
    chk("fetch_dest", 16'(dest), 16'd7);
    chk("fetch_srca", 16'(srcA), 16'd7);
    @(negedge clk);
    #1;
    chk("ir_load", ir, instr);
    chk("exec_state", 16'(execute), 16'd1);
  endtask

  initial begin
    logic [3:0] c4;
    #20;
    chk("rst_fetch", 16'(fetch), 16'd1);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ren", 16'(mem_ren), 16'd0);
    chk("rst_wen", 16'(mem_wen), 16'd0);
    chk("rst_wr", 16'(reg_write), 16'd0);
    chk("rst_ccen", 16'(cc_en), 16'd0);
    chk("rst_exec", 16'(execute), 16'd0);
    chk("rst_mem", 16'(memory), 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("norun_ren", 16'(mem_ren), 16'd0);
    chk("norun_wr", 16'(reg_write), 16'd0);
    @(negedge clk);

    // ADD R1,R2,R3
    do_fetch(16'h014C);
    chk("add_dest", 16'(dest), 16'd1);
    chk("add_srca", 16'(srcA), 16'd2);
    chk("add_srcb", 16'(srcB), 16'd3);
    chk("add_wr", 16'(reg_write), 16'd1);
    chk("add_ccen", 16'(cc_en), 16'd0);
    chk("add_imm", 16'(imm_sel), 16'd0);
    chk("add_func", 16'(alu_func), 16'd0);
    chk("add_ren", 16'(mem_ren), 16'd0);

    // SUB with immediate and flag update
    @(negedge clk);
    do_fetch(16'h3B45);
    chk("sub_ccen", 16'(cc_en), 16'd1);
    chk("sub_imm", 16'(imm_sel), 16'd1);
    chk("sub_func", 16'(alu_func), 16'd1);
    chk("sub_shift", 16'(shift_op), 16'd0);
    chk("sub_dest", 16'(dest), 16'd3);

    // LD R1,[R2,#3]
    @(negedge clk);
    do_fetch(16'hD143);
    chk("ld_ex_imm", 16'(imm_sel), 16'd1);
    chk("ld_ex_wr", 16'(reg_write), 16'd0);
    chk("ld_ex_ccen", 16'(cc_en), 16'd0);
    chk("ld_ex_func", 16'(alu_func), 16'd0);
    chk("ld_ex_shift", 16'(shift_op), 16'd0);
    @(negedge clk);
    #1;
    chk("ld_mem_state", 16'(memory), 16'd1);
    chk("ld_addr_sel", 16'(addr_sel), 16'd1);
    chk("ld_ren", 16'(mem_ren), 16'd1);
    chk("ld_wen", 16'(mem_wen), 16'd0);
    chk("ld_wr", 16'(reg_write), 16'd1);
    chk("ld_dest", 16'(dest), 16'd1);

    // FETCH stall
    @(negedge clk);
    data_in   = 16'hFFFF;
    mem_ready = 1'b0;
    #1;
    chk("stall_fetch", 16'(fetch), 16'd1);
    chk("stall_wr", 16'(reg_write), 16'd0);
    @(negedge clk);
    #1;
    chk("stall_hold", 16'(fetch), 16'd1);
    chk("stall_ir", ir, 16'hD143);

    // ST with two wait cycles
    do_fetch(16'hD943);
    mem_ready = 1'b0;
    chk("st_ex_wr", 16'(reg_write), 16'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("st_wait_mem", 16'(memory), 16'd1);
      chk("st_wait_wen", 16'(mem_wen), 16'd1);
      chk("st_wait_ren", 16'(mem_ren), 16'd0);
      chk("st_wait_srca", 16'(srcA), 16'd1);
      chk("st_wait_wr", 16'(reg_write), 16'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("st_last_mem", 16'(memory), 16'd1);
    chk("st_last_wen", 16'(mem_wen), 16'd1);
    chk("st_last_wr", 16'(reg_write), 16'd0);
    @(negedge clk);
    #1;
    chk("st_done_fetch", 16'(fetch), 16'd1);
    chk("st_done_wen", 16'(mem_wen), 16'd0);

    // BEQ +5
    cc = 4'b0100;
    do_fetch(16'hF705);
    chk("beq_t_wr", 16'(reg_write), 16'd1);
    chk("beq_t_dest", 16'(dest), 16'd7);
    chk("beq_t_srca", 16'(srcA), 16'd7);
    chk("beq_t_imm8", 16'(imm8_sel), 16'd1);
    chk("beq_t_imm", 16'(imm_sel), 16'd1);
    chk("beq_t_func", 16'(alu_func), 16'd0);
    chk("beq_t_ccen", 16'(cc_en), 16'd0);
    cc = 4'b0000;
    #1;
    chk("beq_nt_wr", 16'(reg_write), 16'd0);
    chk("beq_nt_imm8", 16'(imm8_sel), 16'd0);

    // Condition sweep
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      c4 = 4'(c);
      do_fetch({3'b111, 1'b0, c4, 8'h00});
      for (int f = 0; f < 16; f++) begin
        cc = 4'(f);
        #1;
        chk($sformatf("bcc_c%0h_cc%0h", c, f), 16'(reg_write), 16'(bcc_model(c4, 4'(f))));
      end
    end

    // Reset during a stalled store
    cc = 4'h0;
    @(negedge clk);
    do_fetch(16'hD943);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_st_wen_pre", 16'(mem_wen), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_st_wen", 16'(mem_wen), 16'd0);
    chk("rst_st_fetch", 16'(fetch), 16'd1);
    chk("rst_st_ren", 16'(mem_ren), 16'd0);
    chk("rst_st_mem", 16'(memory), 16'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("post_rst_ren0", 16'(mem_ren), 16'd0);
    @(negedge clk);
    #1;
    chk("post_rst_ren1", 16'(mem_ren), 16'd1);
    chk("post_rst_fetch", 16'(fetch), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
